// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// LOADER_CHECKSUM_EN adds the trailing checksum state.
package loader_pkg;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 2;
  localparam int unsigned LEN_W      = 8 * LEN_BYTES;
  localparam int unsigned WORD_W     = 8 * WORD_BYTES;
  localparam logic [7:0]  CSUM_OK    = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERROR
  } state_e;

  // States in which a stream byte may be consumed.
  function automatic logic accepts_byte(input state_e s);
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: return 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Assembles two stream bytes (high byte first) into one instruction word.
module loader_word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_hi,
  input  logic              cap_lo,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (cap_hi) word_d[15:8] = byte_in;
    if (cap_lo) word_d[7:0]  = byte_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/imem_program_loader.sv
// Streams a length-prefixed program into instruction memory and holds the core until done.
// Optional LOADER_CHECKSUM_EN: trailing XOR checksum byte must bring the stream XOR to CSUM_OK.
module imem_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e FINAL_ST = ST_CHECK;
`else
  localparam state_e FINAL_ST = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  len_new;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              im_we_q, im_we_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cap_hi, cap_lo;
  logic              xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // in_ready_q mirrors accepts_byte(state_q), so this is the true handshake.
  assign xfer    = in_valid & in_ready_q;
  assign len_new = {len_q[15:8], in_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    addr_d  = addr_q;
    cap_hi  = 1'b0;
    cap_lo  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LEN_HI;
          count_d = '0;
          addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = in_data;
          if (len_new == '0)                     state_d = FINAL_ST;
          else if (len_new > LEN_W'(IMEM_DEPTH)) state_d = ST_ERROR;
          else                                   state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (xfer) begin
          cap_hi  = 1'b1;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          cap_lo  = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + LEN_W'(1);
        state_d = (count_d < len_q) ? ST_DATA_HI : FINAL_ST;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) state_d = ((csum_q ^ in_data) == CSUM_OK) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef LOADER_CHECKSUM_EN
    if (xfer) csum_d = csum_q ^ in_data;
`endif

    // Outputs are registered copies of the next-state decode.
    in_ready_d = accepts_byte(state_d);
    im_we_d    = (state_d == ST_WRITE);
    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  loader_word_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .cap_hi  (cap_hi),
    .cap_lo  (cap_lo),
    .byte_in (in_data),
    .word    (im_wdata)
  );

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = addr_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized self-checking bench for imem_program_loader against a byte-list program model.
module tb_imem_program_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [15:0]   im_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  imem_program_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_xfer_cyc = -10;
  int last_we_cyc   = -10;
  int done_cyc      = -1;
  bit arm = 1'b0;

  logic [7:0]    prog[$];
  logic [23:0]   got_wr[$];
  logic [23:0]   exp_wr[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor samples 1 time unit after the falling edge, once drivers have settled.
  always @(negedge clk) begin
    #1;
    if (im_we) begin
      got_wr.push_back({im_addr, im_wdata});
      check_val("ready_in_write", {31'b0, in_ready}, 32'd0);
      check_val("we_latency", cyc, last_xfer_cyc + 1);
      last_we_cyc = cyc;
    end
    if (in_valid && in_ready) last_xfer_cyc = cyc;
    if (arm && (done || err) && done_cyc < 0) done_cyc = cyc;
  end

  // Reference model: derives writes and outcome straight from the byte list.
  task automatic compute_expect(output bit ok);
    int unsigned len;
    logic [7:0] x;
    exp_wr.delete();
    len = {prog[0], prog[1]};
    if (len > DEPTH) begin
      ok = 1'b0;
    end else begin
      for (int i = 0; i < int'(len); i++)
        exp_wr.push_back({AW'(i), prog[2 + 2*i], prog[3 + 2*i]});
      ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (prog[i]) x = x ^ prog[i];
      ok = (x == 8'h00);
`endif
    end
  endtask

  task automatic add_csum(input bit bad);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (prog[i]) x = x ^ prog[i];
    prog.push_back(bad ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
`else
    if (bad) prog.push_back(8'h00);
    if (bad) void'(prog.pop_back());
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    bit sent = 1'b0;
    while (!sent) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) sent = 1'b1;
      end
      n++;
      if (n > 200) begin
        check_val("send_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input bit do_start, input bit gaps);
    bit ok;
    int n;
    compute_expect(ok);
    got_wr.delete();
    if (do_start) pulse_start();
    done_cyc = -1;
    arm = 1'b1;
    foreach (prog[i]) send_byte(prog[i], gaps);
    // Keep junk valid high afterwards: finished loader must not consume it.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    n = 0;
    while (done_cyc < 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done_cyc < 0) check_val("finish_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    #2;
    in_valid = 1'b0;
    arm = 1'b0;
    check_val("done", {31'b0, done}, {31'b0, ok});
    check_val("err", {31'b0, err}, {31'b0, !ok});
    check_val("cpu_hold", {31'b0, cpu_hold}, {31'b0, !ok});
    check_val("ready_idle", {31'b0, in_ready}, 32'd0);
    check_val("n_writes", got_wr.size(), exp_wr.size());
    foreach (exp_wr[i])
      if (i < got_wr.size()) check_val("write", {8'h0, got_wr[i]}, {8'h0, exp_wr[i]});
    check_val("im_addr", {24'b0, im_addr}, 32'(exp_wr.size() % (1 << AW)));
`ifndef LOADER_CHECKSUM_EN
    if (ok && exp_wr.size() > 0) check_val("done_latency", done_cyc, last_we_cyc + 1);
    if (ok && exp_wr.size() == 0)
      check_val("len0_latency", {31'b0, (done_cyc - last_xfer_cyc) inside {[1:2]}}, 32'd1);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
    check_val({tag, "_we"}, {31'b0, im_we}, 32'd0);
    check_val({tag, "_addr"}, {24'b0, im_addr}, 32'd0);
    check_val({tag, "_wdata"}, {16'b0, im_wdata}, 32'd0);
    check_val({tag, "_hold"}, {31'b0, cpu_hold}, 32'd1);
    check_val({tag, "_done"}, {31'b0, done}, 32'd0);
    check_val({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  task automatic random_prog(input int unsigned nwords, input bit bad);
    prog.delete();
    prog.push_back(8'(nwords >> 8));
    prog.push_back(8'(nwords));
    for (int unsigned i = 0; i < 2 * nwords; i++) prog.push_back(8'($urandom));
    add_csum(bad);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed three-word program, without and with valid gaps.
    prog = '{8'h00, 8'h03, 8'h10, 8'h41, 8'h20, 8'h82, 8'h31, 8'hC3};
    add_csum(1'b0);
    run_load(1'b1, 1'b0);
    run_load(1'b1, 1'b1);

    // Zero-length program.
    prog = '{8'h00, 8'h00};
    add_csum(1'b0);
    run_load(1'b1, 1'b0);

    // Oversized length, then restart out of ERROR.
    prog = '{8'h01, 8'h01};
    run_load(1'b1, 1'b0);
    pulse_start();
    #2;
    check_val("restart_err", {31'b0, err}, 32'd0);
    check_val("restart_ready", {31'b0, in_ready}, 32'd1);
    check_val("restart_hold", {31'b0, cpu_hold}, 32'd1);
    random_prog(2, 1'b0);
    run_load(1'b0, 1'b1);

    // Reset after the second data word is written.
    random_prog(4, 1'b0);
    got_wr.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(prog[i], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    #2;
    while (got_wr.size() < 2 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_val("pre_reset_writes", got_wr.size(), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    check_reset_outputs("midreset");
    check_val("midreset_writes", got_wr.size(), 32'd2);
    rst_n = 1'b1;
    prog = '{8'h00, 8'h01, 8'hAB, 8'hCD};
    add_csum(1'b0);
    run_load(1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    prog = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    run_load(1'b1, 1'b0);
    prog = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    run_load(1'b1, 1'b0);
`endif

    // Random programs, with a bad checksum now and then when that feature exists.
    for (int k = 0; k < 8; k++) begin
      random_prog($urandom_range(1, 8), ($urandom_range(0, 3) == 0));
      run_load(1'b1, 1'b1);
    end

    // Length boundaries: full memory accepted, one past it rejected.
    random_prog(DEPTH, 1'b0);
    run_load(1'b1, 1'b0);
    prog = '{8'h01, 8'h01};
    run_load(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
